// File: rtl/peripheral_arbiter_wb.sv
// Round-robin Wishbone arbiter: NM masters share one slave; the grant is held for
// a master's whole cycle and a watchdog errors out beats the slave never answers.
module peripheral_arbiter_wb #(
    parameter int NM      = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic [NM*AW-1:0]     m_wb_adr_i,
    input  logic [NM*DW-1:0]     m_wb_dat_i,
    input  logic [NM*DW/8-1:0]   m_wb_sel_i,
    input  logic [NM-1:0]        m_wb_we_i,
    input  logic [NM*3-1:0]      m_wb_cti_i,
    input  logic [NM*2-1:0]      m_wb_bte_i,
    input  logic [NM-1:0]        m_wb_cyc_i,
    input  logic [NM-1:0]        m_wb_stb_i,
    output logic [NM*DW-1:0]     m_wb_dat_o,
    output logic [NM-1:0]        m_wb_ack_o,
    output logic [NM-1:0]        m_wb_err_o,
    output logic [NM-1:0]        m_wb_rty_o,
    output logic [AW-1:0]        s_wb_adr_o,
    output logic [DW-1:0]        s_wb_dat_o,
    output logic [DW/8-1:0]      s_wb_sel_o,
    output logic                 s_wb_we_o,
    output logic [2:0]           s_wb_cti_o,
    output logic [1:0]           s_wb_bte_o,
    output logic                 s_wb_cyc_o,
    output logic                 s_wb_stb_o,
    input  logic [DW-1:0]        s_wb_dat_i,
    input  logic                 s_wb_ack_i,
    input  logic                 s_wb_err_i,
    input  logic                 s_wb_rty_i,
    output logic [NM-1:0]        grant_o,
    output logic                 timeout_o
);

    localparam int LW = (NM > 1) ? $clog2(NM) : 1;
    localparam int SW = DW / 8;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]    state;
    logic [NM-1:0] grant;
    logic [LW-1:0] last;
    logic [15:0]   wdog;

    logic [LW-1:0] winner;
    logic          any_req;
    int            cand;

    // Search starts just after the previous owner, so a master that releases and
    // re-requests at once goes to the back of the line.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        winner  = last;
        any_req = 1'b0;
        cand    = 0;
        for (int i = 1; i <= NM; i++) begin
            cand = (int'(last) + i) % NM;
            if (!any_req && m_wb_cyc_i[cand]) begin
                winner  = LW'(cand);
                any_req = 1'b1;
            end
        end
    end

    // While BUSY, last always holds the index of the granted master.
    logic busy;
    logic g_cyc;
    logic g_stb;
    logic s_resp;
    logic wd_fire;

    assign busy    = (state == BUSY);
    assign g_cyc   = busy & m_wb_cyc_i[last];
    assign g_stb   = busy & m_wb_stb_i[last];
    assign s_resp  = s_wb_ack_i | s_wb_err_i | s_wb_rty_i;
    assign wd_fire = g_stb & ~s_resp & (wdog == 16'(TIMEOUT - 1));

    always_comb begin
        s_wb_adr_o = '0;
        s_wb_dat_o = '0;
        s_wb_sel_o = '0;
        s_wb_we_o  = 1'b0;
        s_wb_cti_o = '0;
        s_wb_bte_o = '0;
        s_wb_cyc_o = 1'b0;
        s_wb_stb_o = 1'b0;
        if (busy) begin
            s_wb_adr_o = m_wb_adr_i[int'(last)*AW +: AW];
            s_wb_dat_o = m_wb_dat_i[int'(last)*DW +: DW];
            s_wb_sel_o = m_wb_sel_i[int'(last)*SW +: SW];
            s_wb_we_o  = m_wb_we_i[last];
            s_wb_cti_o = m_wb_cti_i[int'(last)*3 +: 3];
            s_wb_bte_o = m_wb_bte_i[int'(last)*2 +: 2];
            s_wb_cyc_o = g_cyc;
            s_wb_stb_o = g_stb & ~wd_fire;
        end
    end

    // grant is all-zero in IDLE, which also blocks stray slave responses.
    assign m_wb_dat_o = {NM{s_wb_dat_i}};
    assign m_wb_ack_o = grant & {NM{s_wb_ack_i}};
    assign m_wb_err_o = grant & {NM{s_wb_err_i | wd_fire}};
    assign m_wb_rty_o = grant & {NM{s_wb_rty_i}};
    assign grant_o    = grant;
    assign timeout_o  = wd_fire;

    always_ff @(posedge wb_clk_i) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (wb_rst_i) begin
            state <= IDLE;
            grant <= '0;
            last  <= LW'(NM - 1);
            wdog  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    wdog <= '0;
                    if (any_req) begin
                        state <= BUSY;
                        grant <= NM'(1) << winner;
                        last  <= winner;
                    end
                end
                BUSY: begin
                    if (!g_cyc) begin
                        state <= IDLE;
                        grant <= '0;
                    end
                    if (g_stb && !s_resp && !wd_fire) wdog <= wdog + 16'd1;
                    else                              wdog <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
